// File: rtl/wb_conbus_rr_arb.sv
// Round-robin bus arbiter with forced-grant override and tenure limit.
// All outputs are registered; rst is asynchronous and active-high.
module wb_conbus_rr_arb #(
   parameter int N_MASTERS  = 4,
   parameter int TENURE_MAX = 16,
   localparam int IW = $clog2(N_MASTERS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [N_MASTERS-1:0] req,
   input  logic [N_MASTERS-1:0] grant_master,
   output logic [IW-1:0]        gnt,
   output logic [N_MASTERS-1:0] gnt_oh,
   output logic                 gnt_valid,
   output logic                 gnt_switch
);

   localparam int TW  = $clog2(TENURE_MAX) + 1;
   localparam int SAT = (TENURE_MAX > 0) ? TENURE_MAX - 1 : 0;
   localparam logic [N_MASTERS-1:0] ONE = 1;

   typedef enum logic {PARK, OWN} state_t;

   state_t               state, state_n;
   logic [IW-1:0]        gnt_n;
   logic [N_MASTERS-1:0] oh_n;
   logic                 sw_n;
   logic [TW-1:0]        ten, ten_n, ten_inc;
   logic [IW-1:0]        force_idx;
   logic [IW-1:0]        rr_idx;
   logic                 others;
   logic                 expired;

   always_comb begin
      force_idx = '0;
      for (int i = N_MASTERS - 1; i >= 0; i--) begin
         if (grant_master[i]) force_idx = IW'(i);
      end
   end

   // Search offsets N..1 downward so the nearest requester after gnt wins.
   always_comb begin
      int j;
      rr_idx = gnt;
      for (int k = N_MASTERS; k >= 1; k--) begin
         j = int'(gnt) + k;
         if (j >= N_MASTERS) j = j - N_MASTERS;
         if (req[j]) rr_idx = IW'(j);
      end
   end

   assign others  = |(req & ~(ONE << gnt));
   assign expired = (TENURE_MAX > 0) && (ten == TW'(SAT));
   assign ten_inc = (ten == TW'(SAT)) ? ten : ten + TW'(1);

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      sw_n    = 1'b0;
      ten_n   = ten;
      if (|grant_master) begin
         state_n = OWN;
         gnt_n   = force_idx;
         if (state == OWN && force_idx == gnt) begin
            ten_n = ten_inc;
         end else begin
            sw_n  = 1'b1;
            ten_n = '0;
         end
      end else if (state == PARK) begin
         ten_n = '0;
         if (|req) begin
            state_n = OWN;
            gnt_n   = rr_idx;
            sw_n    = 1'b1;
         end
      end else if (req[gnt] && !(expired && others)) begin
         ten_n = ten_inc;
      end else if (others) begin
         gnt_n = rr_idx;
         sw_n  = 1'b1;
         ten_n = '0;
      end else begin
         state_n = PARK;
         ten_n   = '0;
      end
   end

   always_comb begin
      oh_n = '0;
      if (state_n == OWN) oh_n = ONE << gnt_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= PARK;
         gnt        <= '0;
         gnt_oh     <= '0;
         gnt_valid  <= 1'b0;
         gnt_switch <= 1'b0;
         ten        <= '0;
      end else begin
         state      <= state_n;
         gnt        <= gnt_n;
         gnt_oh     <= oh_n;
         gnt_valid  <= (state_n == OWN);
         gnt_switch <= sw_n;
         ten        <= ten_n;
      end
   end

endmodule

// File: tb/tb_wb_conbus_rr_arb.sv
// Bench for wb_conbus_rr_arb: vector table, corner sequences and
// randomized traffic against a behavioural arbiter model.
module tb_wb_conbus_rr_arb;

   localparam int N   = 4;
   localparam int TEN = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [N-1:0] req = '0;
   logic [N-1:0] gm  = '0;
   logic [1:0]   gnt;
   logic [N-1:0] gnt_oh;
   logic         gnt_valid;
   logic         gnt_switch;

   int total = 0;
   int bad   = 0;

   wb_conbus_rr_arb #(.N_MASTERS(N), .TENURE_MAX(TEN)) dut (
      .clk(clk),
      .rst(rst),
      .req(req),
      .grant_master(gm),
      .gnt(gnt),
      .gnt_oh(gnt_oh),
      .gnt_valid(gnt_valid),
      .gnt_switch(gnt_switch)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_all(input string tag, input int g, input int oh,
                            input int v, input int sw);
      check({tag, ".gnt"}, int'(gnt), g);
      check({tag, ".oh"}, int'(gnt_oh), oh);
      check({tag, ".valid"}, int'(gnt_valid), v);
      check({tag, ".switch"}, int'(gnt_switch), sw);
   endtask

   // Behavioural model: owner index, active flag, cycles held so far.
   int m_owner, m_held;
   bit m_active, m_sw;

   function automatic int lowest(input logic [N-1:0] v);
      for (int i = 0; i < N; i++) if (v[i]) return i;
      return 0;
   endfunction

   function automatic int rr_pick(input logic [N-1:0] r, input int cur);
      for (int d = 1; d <= N; d++) if (r[(cur + d) % N]) return (cur + d) % N;
      return cur;
   endfunction

   task automatic model_reset();
      m_owner = 0; m_held = 0; m_active = 0; m_sw = 0;
   endtask

   task automatic model_step(input logic [N-1:0] r, input logic [N-1:0] g);
      int  nxt;
      bit  oth;
      m_sw = 0;
      if (g != 0) begin
         nxt = lowest(g);
         if (m_active && nxt == m_owner) m_held++;
         else begin m_owner = nxt; m_held = 0; m_sw = 1; end
         m_active = 1;
      end else if (!m_active) begin
         if (r != 0) begin
            m_owner = rr_pick(r, m_owner);
            m_active = 1; m_held = 0; m_sw = 1;
         end
      end else begin
         oth = (r & ~(N'(1) << m_owner)) != 0;
         if (r[m_owner] && !(m_held >= TEN - 1 && oth)) m_held++;
         else if (oth) begin
            m_owner = rr_pick(r, m_owner); m_held = 0; m_sw = 1;
         end else m_active = 0;
      end
   endtask

   typedef struct {
      logic [N-1:0] req;
      logic [N-1:0] gm;
      int           g;
      int           oh;
      int           v;
      int           sw;
   } vec_t;

   vec_t tbl[14];

   initial begin
      tbl[0]  = '{4'b0001, 4'b0000, 0, 4'b0001, 1, 1};
      tbl[1]  = '{4'b0001, 4'b0000, 0, 4'b0001, 1, 0};
      tbl[2]  = '{4'b0100, 4'b0000, 2, 4'b0100, 1, 1};
      tbl[3]  = '{4'b1011, 4'b0000, 3, 4'b1000, 1, 1};
      tbl[4]  = '{4'b0011, 4'b0000, 0, 4'b0001, 1, 1};
      tbl[5]  = '{4'b0000, 4'b0000, 0, 4'b0000, 0, 0};
      tbl[6]  = '{4'b1000, 4'b0000, 3, 4'b1000, 1, 1};
      tbl[7]  = '{4'b0010, 4'b0000, 1, 4'b0010, 1, 1};
      tbl[8]  = '{4'b0010, 4'b0100, 2, 4'b0100, 1, 1};
      tbl[9]  = '{4'b0010, 4'b0000, 1, 4'b0010, 1, 1};
      tbl[10] = '{4'b0010, 4'b0010, 1, 4'b0010, 1, 0};
      tbl[11] = '{4'b0000, 4'b0000, 1, 4'b0000, 0, 0};
      tbl[12] = '{4'b0000, 4'b0001, 0, 4'b0001, 1, 1};
      tbl[13] = '{4'b0000, 4'b0000, 0, 4'b0000, 0, 0};

      repeat (2) @(posedge clk);
      #1 check_all("reset", 0, 0, 0, 0);
      @(negedge clk) rst = 1'b0;

      for (int i = 0; i < 14; i++) begin
         req = tbl[i].req;
         gm  = tbl[i].gm;
         @(posedge clk);
         #1 check_all($sformatf("vec%0d", i), tbl[i].g, tbl[i].oh,
                      tbl[i].v, tbl[i].sw);
         @(negedge clk);
      end

      // Tenure rotation from park at gnt=0: search starts at 1.
      req = 4'b0011; gm = '0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk);
         #1;
         check($sformatf("ten%0d.gnt", k), int'(gnt), ((k / TEN) % 2) ? 0 : 1);
         check($sformatf("ten%0d.sw", k), int'(gnt_switch), (k % TEN) == 0);
         @(negedge clk);
      end

      // Sole requester past expiry keeps the grant.
      req = 4'b0010;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk);
         #1 check_all($sformatf("hold%0d", k), 1, 4'b0010, 1, 0);
         @(negedge clk);
      end

      // Asynchronous reset between edges.
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_all("async_rst", 0, 0, 0, 0);
      @(posedge clk);
      #1 check_all("rst_hold", 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0; req = '0; gm = '0;
      model_reset();

      for (int c = 0; c < 3000; c++) begin
         logic [N-1:0] r, g;
         bit           do_rst;
         r      = N'($urandom);
         g      = ($urandom_range(0, 9) == 0) ? N'($urandom) : '0;
         do_rst = ($urandom_range(0, 199) == 0);
         req = r; gm = g; rst = do_rst;
         @(posedge clk);
         if (do_rst) model_reset();
         else model_step(r, g);
         #1 check_all($sformatf("rnd%0d", c), m_owner,
                      m_active ? (1 << m_owner) : 0, m_active, m_sw);
         @(negedge clk);
      end
      rst = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
